// File: rtl/nvm_prog_ctrl.sv
// NVM program/erase/read command controller.
// Runs one command at a time: word read, word program with read-back verify, and sector erase.
module nvm_prog_ctrl #(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned PROG_CYCLES    = 8,
    parameter int unsigned SECTOR_BITS    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [MEM_DATA_WIDTH-1:0] req_wdata,
    input  logic                      lock,
    output logic                      rsp_valid,
    output logic [MEM_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_wd,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rd
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OFS_W = SECTOR_BITS + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_PROG   = 3'd2;
    localparam logic [2:0] S_PWAIT  = 3'd3;
    localparam logic [2:0] S_VERIFY = 3'd4;
    localparam logic [2:0] S_ERASE  = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [CNT_W-1:0]          WAIT_LOAD   = CNT_W'(PROG_CYCLES - 2);
    localparam logic [MEM_ADDR_WIDTH-1:0] SECTOR_MASK = MEM_ADDR_WIDTH'((1 << SECTOR_BITS) - 1);

    logic [2:0]                r_state;
    logic [1:0]                r_op;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [MEM_DATA_WIDTH-1:0] r_wdata;
    logic [MEM_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;
    logic [CNT_W-1:0]          r_wait_cnt;
    logic [OFS_W-1:0]          r_ofs;

    logic [2:0]                w_state_nxt;
    logic                      w_accept;
    logic                      w_bad_cmd;
    logic [OFS_W-1:0]          w_ofs_inc;
    logic                      w_erase_last;
    logic [MEM_ADDR_WIDTH-1:0] w_erase_addr;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_bad_cmd = (req_op == OP_RSVD) || ((req_op != OP_READ) && lock);
    assign w_ofs_inc = r_ofs + OFS_W'(1);

    // Offset counter carries into its extra bit after the last sector word.
    assign w_erase_last = w_ofs_inc[SECTOR_BITS];
    // Offset is OR-ed into a cleared field, so it never carries into the sector number.
    assign w_erase_addr = (r_addr & ~SECTOR_MASK) | (MEM_ADDR_WIDTH'(r_ofs) & SECTOR_MASK);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and output decode
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = '0;
        mem_we      = 1'b0;
        mem_addr    = r_addr;
        mem_wd      = '0;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                mem_addr  = req_addr;
                if (w_accept) begin
                    if (w_bad_cmd) begin
                        w_state_nxt = S_RESP;
                    end else if (req_op == OP_READ) begin
                        w_state_nxt = S_READ;
                    end else if (req_op == OP_PROG) begin
                        w_state_nxt = S_PROG;
                    end else begin
                        w_state_nxt = S_ERASE;
                    end
                end
            end
            S_READ: begin
                w_state_nxt = S_RESP;
            end
            S_PROG: begin
                mem_we      = 1'b1;
                mem_wd      = r_wdata;
                w_state_nxt = S_PWAIT;
            end
            S_PWAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_VERIFY;
                end
            end
            S_VERIFY: begin
                w_state_nxt = S_RESP;
            end
            S_ERASE: begin
                mem_we   = 1'b1;
                mem_addr = w_erase_addr;
                mem_wd   = '1;
                if (w_erase_last) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid   = 1'b1;
                rsp_err     = r_err;
                rsp_rdata   = (r_op == OP_READ) ? r_rdata : '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latches, wait/offset counters and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
            r_ofs      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rdata <= '0;
                        r_err   <= w_bad_cmd;
                        r_ofs   <= '0;
                    end
                end
                S_READ: begin
                    r_rdata <= mem_rd;
                end
                S_PROG: begin
                    r_wait_cnt <= WAIT_LOAD;
                end
                S_PWAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                S_VERIFY: begin
                    r_err <= (mem_rd != r_wdata);
                end
                S_ERASE: begin
                    r_ofs <= w_erase_last ? '0 : w_ofs_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
